// File: rtl/pipe_y_sequencer.sv
// Pipe-gap Y table sequencer: IDLE/FILL/RUN/HALT control, scroll divider and LFSR Y source.
// Optional macro PIPE_DELTA_LIMIT_EN limits the Y step between adjacent pipes to MAX_DELTA.
module pipe_y_sequencer #(
  parameter int          SLOT_W    = 16,
  parameter int          SLOTS     = 4,
  parameter int          TICK_DIV  = 50000,
  parameter int          Y_MIN     = 60,
  parameter int          Y_MAX     = 380,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_DELTA = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      crash,
  output logic [SLOT_W*SLOTS-1:0]   y_out,
  output logic                      y_load,
  output logic [1:0]                state,
  output logic [7:0]                spawned
);
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(SLOTS + 1);
  localparam logic [9:0] RANGE = 10'(Y_MAX - Y_MIN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, HALT = 2'd3} st_t;

  st_t             st;
  logic [15:0]     lfsr, lfsr_nxt;
  logic [TW-1:0]   tick;
  logic [FW-1:0]   fill_cnt;
  logic [9:0]      r9, r;
  logic [SLOT_W-1:0] y_raw, y_new;

  assign state    = st;
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // RANGE >= 256 guarantees a single subtraction folds r into range
  assign r9    = {1'b0, lfsr[8:0]};
  assign r     = (r9 >= RANGE) ? r9 - RANGE : r9;
  assign y_raw = SLOT_W'(Y_MIN) + SLOT_W'(r);

`ifdef PIPE_DELTA_LIMIT_EN
  logic signed [SLOT_W+1:0] prev, lo, hi, yc;
  logic                     first;

  // slot 0 is stale on the first shift of a fill, so no step limit there
  assign first = (st == FILL) && (fill_cnt == '0);

  always_comb begin
    prev = $signed({2'b00, y_out[SLOT_W-1:0]});
    lo   = prev - $signed((SLOT_W+2)'(MAX_DELTA));
    hi   = prev + $signed((SLOT_W+2)'(MAX_DELTA));
    yc   = $signed({2'b00, y_raw});
    if (!first) begin
      if (yc < lo)      yc = lo;
      else if (yc > hi) yc = hi;
    end
    if (yc < $signed((SLOT_W+2)'(Y_MIN)))      yc = $signed((SLOT_W+2)'(Y_MIN));
    else if (yc > $signed((SLOT_W+2)'(Y_MAX))) yc = $signed((SLOT_W+2)'(Y_MAX));
    y_new = yc[SLOT_W-1:0];
  end
`else
  assign y_new = y_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      lfsr     <= LFSR_SEED;
      y_out    <= '0;
      y_load   <= 1'b0;
      spawned  <= '0;
      tick     <= '0;
      fill_cnt <= '0;
    end else begin
      lfsr   <= lfsr_nxt;
      y_load <= 1'b0;
      case (st)
        IDLE: if (start) begin
          st       <= FILL;
          fill_cnt <= '0;
          spawned  <= '0;
        end
        FILL: begin
          if (crash) begin
            st <= HALT;
          end else if (fill_cnt == FW'(SLOTS)) begin
            // table complete: hand it over one cycle after the last shift
            y_load <= 1'b1;
            st     <= RUN;
            tick   <= '0;
          end else begin
            y_out    <= {y_out[SLOT_W*(SLOTS-1)-1:0], y_new};
            fill_cnt <= fill_cnt + 1'b1;
            if (spawned != 8'hFF) spawned <= spawned + 8'd1;
          end
        end
        RUN: begin
          if (crash) begin
            st <= HALT;
          end else if (!pause) begin
            if (tick == TW'(TICK_DIV - 1)) begin
              tick   <= '0;
              y_out  <= {y_out[SLOT_W*(SLOTS-1)-1:0], y_new};
              y_load <= 1'b1;
              if (spawned != 8'hFF) spawned <= spawned + 8'd1;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        HALT: if (start && !crash) begin
          st       <= FILL;
          fill_cnt <= '0;
          spawned  <= '0;
          tick     <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_y_sequencer.sv
// Directed bench for pipe_y_sequencer (TICK_DIV=4) with an LFSR reference model and a y_load scoreboard.
module tb_pipe_y_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, pause, crash;
  logic [63:0] y_out;
  logic        y_load;
  logic [1:0]  state;
  logic [7:0]  spawned;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [63:0] exp_y = '0;
  logic [63:0] sb[$];

  pipe_y_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .crash(crash),
    .y_out(y_out), .y_load(y_load), .state(state), .spawned(spawned)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] newy(input logic [15:0] l);
    int r;
    r = int'(l[8:0]);
    if (r >= 321) r = r - 321;
    return 16'(60 + r);
  endfunction

  // reference LFSR: advances every clock, reseeded only by rst
  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= adv(m_lfsr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // predict the slot shifted in on the coming edge
  task automatic predict(input bit first, input bit push);
    int y;
    y = int'(newy(m_lfsr));
`ifdef PIPE_DELTA_LIMIT_EN
    if (!first) begin
      if (y < int'(exp_y[15:0]) - 64) y = int'(exp_y[15:0]) - 64;
      if (y > int'(exp_y[15:0]) + 64) y = int'(exp_y[15:0]) + 64;
    end
    if (y < 60)  y = 60;
    if (y > 380) y = 380;
`endif
    exp_y = {exp_y[47:0], 16'(y)};
    if (push) sb.push_back(exp_y);
  endtask

  task automatic pulse_check(input string tag);
    logic [63:0] e;
    chk({tag, "_yload"}, {63'd0, y_load}, 64'd1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_yout"}, y_out, e);
    end
  endtask

  task automatic do_fill();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fill_state0", 64'(state), 64'd1);
    chk("fill_spawn0", 64'(spawned), 64'd0);
    for (int i = 0; i < 4; i++) begin
      predict(i == 0, i == 3);
      step();
      chk("fill_noload", {63'd0, y_load}, 64'd0);
    end
    step();
    pulse_check("fill");
    chk("fill_spawned", 64'(spawned), 64'd4);
    chk("fill_state", 64'(state), 64'd2);
    for (int s = 0; s < 4; s++)
      chk("fill_range", 64'(y_out[s*16 +: 16] >= 16'd60 && y_out[s*16 +: 16] <= 16'd380), 64'd1);
  endtask

  task automatic run_period();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("run_gap", {63'd0, y_load}, 64'd0);
    end
    predict(1'b0, 1'b1);
    step();
    pulse_check("run");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; crash = 1'b0;
    repeat (3) step();
    chk("rst_yout", y_out, 64'd0);
    chk("rst_yload", {63'd0, y_load}, 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_spawned", 64'(spawned), 64'd0);
    rst = 1'b0;
    repeat (20) begin
      step();
      chk("idle_noload", {63'd0, y_load}, 64'd0);
    end

    do_fill();
    for (int i = 0; i < 10; i++) run_period();
    chk("run_spawned", 64'(spawned), 64'd14);

    // pause mid-period: tick is 1 when pause rises
    step();
    chk("prepause_gap", {63'd0, y_load}, 64'd0);
    pause = 1'b1;
    repeat (9) begin
      step();
      chk("pause_noload", {63'd0, y_load}, 64'd0);
      chk("pause_frozen", y_out, exp_y);
    end
    pause = 1'b0;
    repeat (2) begin
      step();
      chk("resume_gap", {63'd0, y_load}, 64'd0);
    end
    predict(1'b0, 1'b1);
    step();
    pulse_check("resume");

    // crash and start together in RUN
    step();
    crash = 1'b1; start = 1'b1;
    step();
    crash = 1'b0; start = 1'b0;
    chk("crash_state", 64'(state), 64'd3);
    chk("crash_noload", {63'd0, y_load}, 64'd0);
    repeat (5) begin
      step();
      chk("halt_frozen", y_out, exp_y);
      chk("halt_noload", {63'd0, y_load}, 64'd0);
      chk("halt_state", 64'(state), 64'd3);
    end

    do_fill();
    run_period();

`ifdef PIPE_DELTA_LIMIT_EN
    for (int i = 0; i < 250; i++) begin
      run_period();
      chk("delta_limit",
          64'((y_out[15:0] > y_out[31:16] ? y_out[15:0] - y_out[31:16]
                                          : y_out[31:16] - y_out[15:0]) <= 16'd64), 64'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
